// File: rtl/uart_bus_bridge.sv
// uart_bus_bridge: decodes 'W'/'R' command frames arriving on the UART byte
// interface into single bus write/read cycles and answers the host with
// 'K', four read-data bytes, or 'E' for an unknown opcode.
module uart_bus_bridge #(
   parameter int unsigned TIMEOUT = 1_000_000,
   parameter logic [7:0]  OP_WR   = 8'h57,
   parameter logic [7:0]  OP_RD   = 8'h52
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   input  logic        tx_ready,
   output logic [7:0]  tx_data,
   output logic        tx_start,
   output logic        rd,
   output logic        wr,
   output logic [31:0] addr,
   output logic [31:0] wdata,
   input  logic [31:0] rdata,
   output logic        busy,
   output logic        frame_err
);

   localparam int unsigned   TW      = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_ADDR   = 3'd1;
   localparam logic [2:0] S_DATA   = 3'd2;
   localparam logic [2:0] S_BUS_WR = 3'd3;
   localparam logic [2:0] S_BUS_RD = 3'd4;
   localparam logic [2:0] S_RESP   = 3'd5;

   logic [2:0]    state;
   logic          is_wr;
   logic [1:0]    byte_cnt;
   logic [TW-1:0] to_cnt;
   logic [31:0]   shreg;
   logic [2:0]    resp_cnt;
   logic          tx_start_q;
   logic          in_frame;
   logic          to_expire;
   logic          bad_op;

   // Bus strobes, TX handshake and error pulse decoded from the current state
   always_comb begin
      in_frame  = (state == S_ADDR) || (state == S_DATA);
      to_expire = in_frame && !rx_valid && (to_cnt == TO_LAST);
      bad_op    = (state == S_IDLE) && rx_valid &&
                  (rx_data != OP_WR) && (rx_data != OP_RD);
      rd        = (state == S_BUS_RD);
      wr        = (state == S_BUS_WR);
      busy      = (state != S_IDLE);
      tx_data   = shreg[31:24];
      // tx_ready is not trusted in the cycle right after our own pulse
      tx_start  = (state == S_RESP) && tx_ready && !tx_start_q;
      frame_err = to_expire || bad_op;
   end

   // Frame decoder FSM with address/data shifters and response shift register
   always_ff @(posedge clk) begin
      if (!reset) begin
         state      <= S_IDLE;
         is_wr      <= 1'b0;
         byte_cnt   <= '0;
         to_cnt     <= '0;
         shreg      <= '0;
         resp_cnt   <= '0;
         tx_start_q <= 1'b0;
         addr       <= '0;
         wdata      <= '0;
      end else begin
         tx_start_q <= tx_start;
         case (state)
            S_IDLE: begin
               byte_cnt <= '0;
               to_cnt   <= '0;
               if (rx_valid) begin
                  if (bad_op) begin
                     shreg    <= {8'h45, 24'h0};
                     resp_cnt <= 3'd1;
                     state    <= S_RESP;
                  end else begin
                     is_wr <= (rx_data == OP_WR);
                     state <= S_ADDR;
                  end
               end
            end
            S_ADDR: begin
               // an incoming byte takes priority over timeout expiry
               if (rx_valid) begin
                  addr     <= {addr[23:0], rx_data};
                  to_cnt   <= '0;
                  byte_cnt <= byte_cnt + 2'd1;
                  if (byte_cnt == 2'd3)
                     state <= is_wr ? S_DATA : S_BUS_RD;
               end else if (to_expire) begin
                  to_cnt <= '0;
                  state  <= S_IDLE;
               end else begin
                  to_cnt <= to_cnt + TW'(1);
               end
            end
            S_DATA: begin
               if (rx_valid) begin
                  wdata    <= {wdata[23:0], rx_data};
                  to_cnt   <= '0;
                  byte_cnt <= byte_cnt + 2'd1;
                  if (byte_cnt == 2'd3)
                     state <= S_BUS_WR;
               end else if (to_expire) begin
                  to_cnt <= '0;
                  state  <= S_IDLE;
               end else begin
                  to_cnt <= to_cnt + TW'(1);
               end
            end
            S_BUS_WR: begin
               shreg    <= {8'h4B, 24'h0};
               resp_cnt <= 3'd1;
               state    <= S_RESP;
            end
            S_BUS_RD: begin
               shreg    <= rdata;
               resp_cnt <= 3'd4;
               state    <= S_RESP;
            end
            S_RESP: begin
               if (tx_start) begin
                  shreg    <= {shreg[23:0], 8'h00};
                  resp_cnt <= resp_cnt - 3'd1;
                  if (resp_cnt == 3'd1)
                     state <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_bus_bridge.sv
// tb_uart_bus_bridge: table-driven frames plus hand-written timing sequences,
// checked against a scoreboard of expected bus cycles and TX bytes.
module tb_uart_bus_bridge;

   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        tx_ready = 1'b1;
   logic [7:0]  tx_data;
   logic        tx_start;
   logic        rd;
   logic        wr;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        busy;
   logic        frame_err;

   uart_bus_bridge #(.TIMEOUT(16), .OP_WR(8'h57), .OP_RD(8'h52)) dut (
      .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
      .tx_ready(tx_ready), .tx_data(tx_data), .tx_start(tx_start),
      .rd(rd), .wr(wr), .addr(addr), .wdata(wdata), .rdata(rdata),
      .busy(busy), .frame_err(frame_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        is_wr;
      logic [31:0] addr;
      logic [31:0] wdata;
   } bus_t;

   typedef struct {
      logic        is_wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rsp;
      int          nrsp;
   } vec_t;

   bus_t       exp_bus[$];
   logic [7:0] exp_tx[$];
   int         tx_log[$];
   int n_cmp = 0, n_bad = 0;
   int cyc = 0;
   int tx_cnt = 0, wr_cnt = 0, rd_cnt = 0, err_cnt = 0;
   int last_tx_cyc = -10, last_wr_cyc = -1, last_rd_cyc = -1, last_err_cyc = -1;
   int strobe = 0;
   int tx_hold = 0;
   logic [31:0] last_wdata = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Responder model: one known register, otherwise inverted address
   always_comb rdata = (addr == 32'h40000010) ? 32'h12345678 : ~addr;

   always @(posedge clk) cyc <= cyc + 1;

   // Transmitter model: busy for three cycles after each start pulse
   always @(posedge clk) begin
      if (tx_start) begin
         tx_ready <= 1'b0;
         tx_hold  <= 3;
      end else if (tx_hold > 0) begin
         tx_hold <= tx_hold - 1;
         if (tx_hold == 1) tx_ready <= 1'b1;
      end
   end

   // Output monitor / scoreboard
   always @(negedge clk) begin
      bus_t e;
      logic [7:0] b;
      if (rd && wr) chk("rd_wr_exclusive", {31'b0, rd & wr}, 32'd0);
      if (rd || wr) begin
         chk("bus_cycle_expected", {31'b0, exp_bus.size() > 0}, 32'd1);
         if (exp_bus.size() > 0) begin
            e = exp_bus.pop_front();
            chk("bus_kind_wr", {31'b0, wr}, {31'b0, e.is_wr});
            chk("bus_addr", addr, e.addr);
            if (wr) chk("bus_wdata", wdata, e.wdata);
         end
         if (wr) begin wr_cnt++; last_wr_cyc = cyc; end
         if (rd) begin rd_cnt++; last_rd_cyc = cyc; end
      end
      if (tx_start) begin
         chk("tx_ready_at_start", {31'b0, tx_ready}, 32'd1);
         chk("tx_spacing_ge2", {31'b0, (cyc - last_tx_cyc) >= 2}, 32'd1);
         chk("tx_expected", {31'b0, exp_tx.size() > 0}, 32'd1);
         if (exp_tx.size() > 0) begin
            b = exp_tx.pop_front();
            chk("tx_data", {24'b0, tx_data}, {24'b0, b});
         end
         tx_cnt++;
         last_tx_cyc = cyc;
         tx_log.push_back(cyc);
      end
      if (frame_err) begin
         err_cnt++;
         last_err_cyc = cyc;
      end
   end

   // Called at posedge+1; holds rx_valid for exactly one cycle
   task automatic send_byte(input logic [7:0] b, input int gap);
      if (gap > 0) begin
         repeat (gap) @(posedge clk);
         #1;
      end
      rx_data  = b;
      rx_valid = 1'b1;
      strobe   = cyc;
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
      rx_data  = 8'($urandom);
   endtask

   task automatic send_frame(input logic is_wr, input logic [31:0] a,
                             input logic [31:0] d, input int gapmax);
      send_byte(is_wr ? 8'h57 : 8'h52, int'($urandom_range(gapmax, 0)));
      for (int k = 0; k < 4; k++)
         send_byte(a[31-8*k -: 8], int'($urandom_range(gapmax, 0)));
      if (is_wr)
         for (int k = 0; k < 4; k++)
            send_byte(d[31-8*k -: 8], int'($urandom_range(gapmax, 0)));
   endtask

   task automatic push_expect(input vec_t v);
      bus_t e;
      logic [7:0] b;
      e.is_wr = v.is_wr; e.addr = v.addr; e.wdata = v.wdata;
      exp_bus.push_back(e);
      for (int k = 0; k < v.nrsp; k++) begin
         b = v.rsp[31-8*k -: 8];
         exp_tx.push_back(b);
      end
      if (v.is_wr) last_wdata = v.wdata;
   endtask

   task automatic wait_idle(input string name);
      for (int i = 0; i < 400; i++) begin
         if (!busy && exp_tx.size() == 0 && exp_bus.size() == 0) break;
         @(posedge clk);
         #1;
      end
      chk({name, "_busy"}, {31'b0, busy}, 32'd0);
      chk({name, "_tx_left"}, exp_tx.size(), 32'd0);
      chk({name, "_bus_left"}, exp_bus.size(), 32'd0);
   endtask

   task automatic settle();
      repeat (6) @(posedge clk);
      #1;
   endtask

   task automatic wait_tx(input int target);
      for (int i = 0; i < 200 && tx_cnt < target; i++) begin
         @(posedge clk);
         #1;
      end
      chk("wait_tx_count", tx_cnt, target);
   endtask

   task automatic chk_reset_outputs(input string name);
      chk({name, "_rd"}, {31'b0, rd}, 32'd0);
      chk({name, "_wr"}, {31'b0, wr}, 32'd0);
      chk({name, "_addr"}, addr, 32'd0);
      chk({name, "_wdata"}, wdata, 32'd0);
      chk({name, "_tx_start"}, {31'b0, tx_start}, 32'd0);
      chk({name, "_tx_data"}, {24'b0, tx_data}, 32'd0);
      chk({name, "_busy"}, {31'b0, busy}, 32'd0);
      chk({name, "_frame_err"}, {31'b0, frame_err}, 32'd0);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs[6];
      vec_t v;
      int n, base, e0, t0, w0, l0;

      vecs[0] = '{1'b1, 32'h0000000C, 32'h000000A5, 32'h4B000000, 1};
      vecs[1] = '{1'b0, 32'h40000010, 32'h00000000, 32'h12345678, 4};
      vecs[2] = '{1'b1, 32'hFFFFFFFF, 32'h12345678, 32'h4B000000, 1};
      vecs[3] = '{1'b0, 32'h000000FF, 32'h00000000, 32'hFFFFFF00, 4};
      vecs[4] = '{1'b1, 32'h80000001, 32'hDEADBEEF, 32'h4B000000, 1};
      vecs[5] = '{1'b0, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 4};

      reset = 1'b0; rx_valid = 1'b0; rx_data = '0;
      repeat (3) @(posedge clk);
      #1;
      chk_reset_outputs("reset");
      reset = 1'b1;
      @(posedge clk);
      #1;

      // table-driven frames with random inter-byte gaps
      for (int i = 0; i < 6; i++) begin
         push_expect(vecs[i]);
         send_frame(vecs[i].is_wr, vecs[i].addr, vecs[i].wdata, 3);
         wait_idle("table");
         chk("hold_addr", addr, vecs[i].addr);
         chk("hold_wdata", wdata, last_wdata);
      end

      // write latency: wr at N+1, 'K' at N+2
      settle();
      w0 = wr_cnt; base = tx_log.size();
      v = '{1'b1, 32'h0000000C, 32'h000000A5, 32'h4B000000, 1};
      push_expect(v);
      send_frame(1'b1, v.addr, v.wdata, 0);
      n = strobe;
      wait_idle("wr_lat");
      chk("wr_cycle", last_wr_cyc, n + 1);
      chk("wr_pulses", wr_cnt - w0, 32'd1);
      chk("k_cycle", tx_log[base], n + 2);

      // read latency and TX pacing
      settle();
      base = tx_log.size();
      v = '{1'b0, 32'h40000010, 32'h0, 32'h12345678, 4};
      push_expect(v);
      send_frame(1'b0, v.addr, v.wdata, 0);
      n = strobe;
      wait_idle("rd_lat");
      chk("rd_cycle", last_rd_cyc, n + 1);
      chk("rd_first_tx", tx_log[base], n + 2);
      chk("rd_tx_pace", tx_log[base+3] - tx_log[base+2], 32'd4);

      // bad opcode: 'E', frame_err in the strobe cycle, then a normal frame
      settle();
      e0 = err_cnt; base = tx_log.size(); w0 = wr_cnt + rd_cnt;
      exp_tx.push_back(8'h45);
      send_byte(8'h33, 0);
      n = strobe;
      wait_idle("badop");
      chk("badop_err_cycle", last_err_cyc, n);
      chk("badop_err_count", err_cnt - e0, 32'd1);
      chk("badop_tx_cycle", tx_log[base], n + 1);
      chk("badop_no_bus", wr_cnt + rd_cnt - w0, 32'd0);
      push_expect(vecs[3]);
      send_frame(1'b0, vecs[3].addr, vecs[3].wdata, 1);
      wait_idle("after_badop");

      // timeout: frame abandoned 16 cycles after the last byte
      settle();
      e0 = err_cnt; t0 = tx_cnt; w0 = wr_cnt;
      send_byte(8'h57, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
      l0 = strobe;
      for (int i = 0; i < 40 && cyc < l0 + 20; i++) begin
         @(posedge clk);
         #1;
      end
      chk("to_err_cycle", last_err_cyc, l0 + 16);
      chk("to_err_count", err_cnt - e0, 32'd1);
      chk("to_busy", {31'b0, busy}, 32'd0);
      chk("to_no_tx", tx_cnt - t0, 32'd0);
      chk("to_no_wr", wr_cnt - w0, 32'd0);

      // byte at the expiry cycle wins and the frame continues
      e0 = err_cnt;
      v = '{1'b1, 32'h0000ABCD, 32'h11223344, 32'h4B000000, 1};
      push_expect(v);
      send_byte(8'h57, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
      l0 = strobe;
      send_byte(8'hAB, 15);
      chk("to_late_byte_cycle", strobe, l0 + 16);
      send_byte(8'hCD, 0);
      for (int k = 0; k < 4; k++) send_byte(v.wdata[31-8*k -: 8], 0);
      wait_idle("to_rescue");
      chk("to_rescue_no_err", err_cnt - e0, 32'd0);

      // overrun: bytes during RESP are dropped
      settle();
      e0 = err_cnt; t0 = tx_cnt;
      push_expect(vecs[1]);
      send_frame(1'b0, vecs[1].addr, vecs[1].wdata, 0);
      wait_tx(t0 + 1);
      chk("ovr_busy_in_resp", {31'b0, busy}, 32'd1);
      send_byte(8'h57, 0); send_byte(8'h33, 0); send_byte(8'h52, 0);
      wait_idle("overrun");
      chk("ovr_no_err", err_cnt - e0, 32'd0);
      chk("ovr_tx_count", tx_cnt - t0, 32'd4);
      push_expect(vecs[4]);
      send_frame(1'b1, vecs[4].addr, vecs[4].wdata, 0);
      wait_idle("after_overrun");

      // reset during the 2nd byte of a read response
      settle();
      t0 = tx_cnt;
      v = '{1'b0, 32'h00000010, 32'h0, 32'hFFFFFFEF, 4};
      push_expect(v);
      send_frame(1'b0, v.addr, v.wdata, 0);
      wait_tx(t0 + 2);
      reset = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b1;
      chk_reset_outputs("midreset");
      chk("midreset_abandoned", exp_tx.size(), 32'd2);
      exp_tx.delete();
      repeat (30) @(posedge clk);
      #1;
      chk("midreset_no_tx", tx_cnt - t0, 32'd2);
      last_wdata = '0;
      push_expect(vecs[2]);
      send_frame(1'b1, vecs[2].addr, vecs[2].wdata, 2);
      wait_idle("after_reset");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
